pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Consumer of the pc_src selection code from the next-PC logic. Holds the architectural PC, issues instruction-fetch requests over a valid/ready handshake to instruction memory, and presents the fetched instruction to decode. On each commit pulse it computes the next PC:
- 00: pc+4
- 01: pc+imm
- 10: (rs1+imm) with bit 0 cleared
- 11: csr_pc

It then starts the next fetch. It sits between the next-PC logic and the instruction memory port of the scpu core.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
pc_src  input  2  next-PC select code (00 pc+4, 01 pc+imm, 10 rs1+imm, 11 csr_pc)
imm  input  XLEN  immediate from decode
rs1  input  XLEN  rs1 value from register file
csr_pc  input  XLEN  mepc/mtvec target from CSR unit
commit  input  1  single-cycle pulse: current instruction completes; pc_src/imm/rs1/csr_pc valid this cycle
pc  output  XLEN  current architectural PC
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  XLEN  fetch address (equals pc)
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  instruction data valid
imem_rsp_data  input  32  instruction word
imem_rsp_ready  output  1  controller accepts response
inst  output  32  latched instruction for decode
inst_valid  output  1  inst is valid; core may execute
misalign  output  1  sticky: computed target had pc[1:0]!=0

Behaviour:
- Reset (async, rst=1): state=REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_valid=0, misalign=0. Outputs take these values immediately, not at a clock edge.
- States: REQ, WAIT, EXEC, HALT. Two-bit encoded, registered.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc, imem_rsp_ready=0.
  - On imem_req_valid && imem_req_ready at a clock edge, go to WAIT.
  - imem_req_addr is held stable while valid and not ready.
- WAIT:
  - imem_req_valid=0, imem_rsp_ready=1.
  - On imem_rsp_valid, latch inst<=imem_rsp_data, set inst_valid<=1, go to EXEC.
  - A response arriving in the same cycle as the request handshake is not accepted; it must come at least one cycle later.
- EXEC:
  - inst_valid=1, no memory activity.
  - On commit, compute next per pc_src. All additions are modulo 2^XLEN with no overflow flag.
  - If next[1:0]==0: pc<=next, inst_valid<=0, go to REQ.
  - Else: misalign<=1, pc unchanged, inst_valid<=0, go to HALT.
- Fetch latency: REQ is entered the cycle after commit. With zero-wait memory (ready=1, rsp next cycle), inst_valid rises 2 cycles after entering REQ.
- commit outside EXEC is ignored, with no state or pc change.
- HALT: absorbing state; all handshake outputs 0, inst_valid=0. Left only by rst.
- pc_src=10 clears bit 0 of the sum before the alignment check, so rs1+imm=0x8000_0005 gives 0x8000_0004 (aligned).
- Reset asserted mid-transaction (REQ, WAIT, or EXEC) aborts it. Any response in flight after reset release is not accepted until a new request has handshaken.
- pc changes only on a commit in EXEC or on reset.

Test Plan:
- Reset then zero-wait memory returning 0x00000093 -> imem_req_addr=0x8000_0000, inst=0x00000093, inst_valid=1 two cycles after reset release.
- commit with pc_src=00 at pc=0x8000_0000 -> next request addr 0x8000_0004. commit with pc_src=01, imm=0xFFFF_FFF8 at pc=0x8000_0004 -> addr 0x7FFF_FFFC.
- pc_src=10, rs1=0x8000_0100, imm=0x5 -> addr 0x8000_0104. pc_src=11, csr_pc=0x8000_1000 -> addr 0x8000_1000.
- imem_req_ready held low 3 cycles, then imem_rsp_valid delayed 4 cycles -> addr stable throughout, exactly one request handshake, inst_valid rises only after the response.
- pc_src=01, imm=0x2 -> misalign=1, pc stays 0x8000_0000, no further imem_req_valid. Asserting rst restores pc=RESET_PC and misalign=0.
- rst asserted while in WAIT and commit pulsed outside EXEC -> state=REQ, pc=0x8000_0000 asynchronously; stray commit causes no pc change.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// PC holder and instruction-fetch controller: issues one fetch per instruction,
// latches the returned word for decode, and selects the next PC on commit.
module pc_fetch_ctrl #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] csr_pc,
    input  logic            commit,
    output logic [XLEN-1:0] pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            imem_rsp_ready,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic            misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_EXEC = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] rs1_sum;
    logic [XLEN-1:0] next_pc;

    // Target selection; all sums wrap modulo 2^XLEN.
    always_comb begin
        rs1_sum = rs1 + imm;
        next_pc = pc_q + XLEN'(4);
        case (pc_src)
            2'b00:   next_pc = pc_q + XLEN'(4);
            2'b01:   next_pc = pc_q + imm;
            2'b10:   next_pc = {rs1_sum[XLEN-1:1], 1'b0};
            default: next_pc = csr_pc;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;

        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d       = imem_rsp_data;
                    inst_valid_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    inst_valid_d = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end
                end
            end
            default: begin
                inst_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    always_comb begin
        pc             = pc_q;
        imem_req_addr  = pc_q;
        imem_req_valid = (state_q == S_REQ);
        imem_rsp_ready = (state_q == S_WAIT);
        inst           = inst_q;
        inst_valid     = inst_valid_q;
        misalign       = misalign_q;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: expected fetch addresses and instruction
// words are queued when stimulus is driven and compared when the DUT produces them.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] csr_pc = '0;
    logic        commit = 1'b0;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        misalign;

    int vectors = 0;
    int errors  = 0;
    int hs_count = 0;

    logic [31:0] pc_model;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];

    pc_fetch_ctrl #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_src         (pc_src),
        .imm            (imm),
        .rs1            (rs1),
        .csr_pc         (csr_pc),
        .commit         (commit),
        .pc             (pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_ready (imem_rsp_ready),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) hs_count <= hs_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch starting at a negedge with the DUT in REQ.
    task automatic fetch(input int rdy_dly, input int rsp_dly, input logic [31:0] word);
        logic [31:0] exp_addr;
        logic [31:0] exp_word;
        int          hs0;
        exp_addr = 32'hxxxx_xxxx;
        if (exp_addr_q.size() == 0) check("addr_queue_empty", 32'd0, 32'd1);
        else exp_addr = exp_addr_q.pop_front();
        exp_inst_q.push_back(word);
        hs0 = hs_count;
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_req_addr, exp_addr);
        check("pc_at_req", pc, exp_addr);
        for (int i = 0; i < rdy_dly; i++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            check("addr_stable", imem_req_addr, exp_addr);
            check("req_valid_held", 32'(imem_req_valid), 32'd1);
        end
        // A response coinciding with the request handshake must be ignored.
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        check("req_drop", 32'(imem_req_valid), 32'd0);
        check("rsp_ready", 32'(imem_rsp_ready), 32'd1);
        check("inst_valid_wait", 32'(inst_valid), 32'd0);
        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge clk);
            check("inst_valid_early", 32'(inst_valid), 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        exp_word = exp_inst_q.pop_front();
        check("inst_valid", 32'(inst_valid), 32'd1);
        check("inst", inst, exp_word);
        check("rsp_ready_exec", 32'(imem_rsp_ready), 32'd0);
        check("one_handshake", 32'(hs_count - hs0), 32'd1);
    endtask

    // Commit starting at a negedge with the DUT in EXEC.
    task automatic do_commit(input logic [1:0] src, input logic [31:0] i_imm,
                             input logic [31:0] i_rs1, input logic [31:0] i_csr);
        logic [31:0] nxt;
        logic [31:0] s;
        case (src)
            2'b00: nxt = pc_model + 32'd4;
            2'b01: nxt = pc_model + i_imm;
            2'b10: begin s = i_rs1 + i_imm; nxt = s & 32'hFFFF_FFFE; end
            default: nxt = i_csr;
        endcase
        pc_src = src; imm = i_imm; rs1 = i_rs1; csr_pc = i_csr; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check("inst_valid_after_commit", 32'(inst_valid), 32'd0);
        if (nxt[1:0] == 2'b00) begin
            pc_model = nxt;
            exp_addr_q.push_back(nxt);
            check("pc_after_commit", pc, nxt);
            check("req_after_commit", 32'(imem_req_valid), 32'd1);
        end else begin
            check("misalign_set", 32'(misalign), 32'd1);
            check("pc_hold_misalign", pc, pc_model);
            check("req_halt", 32'(imem_req_valid), 32'd0);
        end
    endtask

    initial begin
        int hs0;
        // Asynchronous reset: outputs must settle without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
        pc_model = RESET_PC;
        exp_addr_q.push_back(RESET_PC);
        @(negedge clk);
        rst = 1'b0;

        fetch(0, 0, 32'h0000_0093);
        do_commit(2'b00, 32'h0, 32'h0, 32'h0);
        fetch(0, 0, 32'h0010_0113);
        do_commit(2'b01, 32'hFFFF_FFF8, 32'h0, 32'h0);
        fetch(0, 0, 32'h0020_0193);
        do_commit(2'b10, 32'h0000_0005, 32'h8000_0100, 32'h0);
        fetch(0, 0, 32'h0030_0213);
        do_commit(2'b11, 32'h0, 32'h0, 32'h8000_1000);
        fetch(3, 4, 32'h0040_0293);
        do_commit(2'b10, 32'h0000_0005, 32'h8000_0000, 32'h0);
        fetch(1, 1, 32'h0050_0313);

        // Abort a fetch in WAIT with an asynchronous reset.
        do_commit(2'b00, 32'h0, 32'h0, 32'h0);
        void'(exp_addr_q.pop_front());
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("wait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_pc", pc, RESET_PC);
        check("midrst_req_valid", 32'(imem_req_valid), 32'd1);
        check("midrst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
        check("midrst_inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pc_model = RESET_PC;
        // Stray commit plus leftover response while in REQ.
        commit = 1'b1; pc_src = 2'b11; csr_pc = 32'h1234_0000;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAAD_F00D;
        @(negedge clk);
        commit = 1'b0; imem_rsp_valid = 1'b0;
        check("stray_commit_pc", pc, RESET_PC);
        check("stray_req_valid", 32'(imem_req_valid), 32'd1);
        check("stray_inst_valid", 32'(inst_valid), 32'd0);
        exp_addr_q.push_back(RESET_PC);
        fetch(0, 0, 32'h0000_0093);

        // Misaligned target halts the controller.
        do_commit(2'b01, 32'h0000_0002, 32'h0, 32'h0);
        hs0 = hs_count;
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
            commit = 1'b1; pc_src = 2'b00;
            @(negedge clk);
            check("halt_req_valid", 32'(imem_req_valid), 32'd0);
            check("halt_rsp_ready", 32'(imem_rsp_ready), 32'd0);
            check("halt_inst_valid", 32'(inst_valid), 32'd0);
            check("halt_pc", pc, RESET_PC);
            check("halt_misalign", 32'(misalign), 32'd1);
        end
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; commit = 1'b0;
        check("halt_no_handshake", 32'(hs_count - hs0), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("halt_rst_pc", pc, RESET_PC);
        check("halt_rst_misalign", 32'(misalign), 32'd0);
        check("halt_rst_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        check("inst_queue_drained", 32'(exp_inst_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
